// File: rtl/gpio_in_filter.sv
// -----------------------------------------------------------------------------
// gpio_in_filter
// Per-pin input conditioning between the pad wrapper and the GPIO register
// block: synchronises each asynchronous pad level, optionally debounces it with
// a prescaled glitch filter, and emits one-cycle rise/fall event pulses.
//
// Ports
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   pin_i       raw pad levels, asynchronous to clk
//   filt_en     per-pin filter enable (0 = synchronise only)
//   filt_len    ticks a new level must persist before acceptance (0 acts as 1)
//   prescale_i  tick period minus one, in clk cycles
//   gpio_o      conditioned level, registered
//   rise_o      one-cycle pulse when a gpio_o bit goes 0->1
//   fall_o      one-cycle pulse when a gpio_o bit goes 1->0
// -----------------------------------------------------------------------------
module gpio_in_filter #(
  parameter int unsigned NUM_BITS    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PRE_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_BITS-1:0]  pin_i,
  input  logic [NUM_BITS-1:0]  filt_en,
  input  logic [CNT_WIDTH-1:0] filt_len,
  input  logic [PRE_WIDTH-1:0] prescale_i,
  output logic [NUM_BITS-1:0]  gpio_o,
  output logic [NUM_BITS-1:0]  rise_o,
  output logic [NUM_BITS-1:0]  fall_o
);

  // One extra bit so cnt+1 never overflows in the acceptance compare.
  localparam int unsigned CW1 = CNT_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // Synchroniser chain; the last stage is the only view of the pad level.
  // ---------------------------------------------------------------------------
  logic [NUM_BITS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BITS-1:0] sync_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= pin_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Shared prescaler: ticks when the count reaches prescale_i. A count already
  // above a newly lowered prescale_i wraps to 0 without producing a tick.
  // ---------------------------------------------------------------------------
  logic [PRE_WIDTH-1:0] pre_cnt_q;
  logic [PRE_WIDTH-1:0] pre_cnt_d;
  logic                 tick_c;

  always_comb begin
    tick_c    = (pre_cnt_q == prescale_i);
    pre_cnt_d = (pre_cnt_q >= prescale_i) ? '0 : pre_cnt_q + PRE_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-pin debounce / bypass next-state logic.
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_BITS];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_BITS];
  logic [CW1-1:0]       cnt_inc [NUM_BITS];
  logic [CW1-1:0]       flen_c;
  logic [NUM_BITS-1:0]  gpio_q;
  logic [NUM_BITS-1:0]  gpio_d;
  logic [NUM_BITS-1:0]  rise_q;
  logic [NUM_BITS-1:0]  fall_q;

  // A zero length behaves as one tick.
  assign flen_c = (filt_len == '0) ? CW1'(1) : {1'b0, filt_len};

  always_comb begin
    gpio_d = gpio_q;
    for (int i = 0; i < NUM_BITS; i++) begin
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = {1'b0, cnt_q[i]} + CW1'(1);
    end

    for (int i = 0; i < NUM_BITS; i++) begin
      if (!filt_en[i]) begin
        gpio_d[i] = sync_c[i];
        cnt_d[i]  = '0;
      end else if (sync_c[i] == gpio_q[i]) begin
        // Level returned to the accepted value: discard any partial run.
        cnt_d[i] = '0;
      end else if (tick_c) begin
        // >= so a filt_len lowered below a running count accepts on this tick.
        if (cnt_inc[i] >= flen_c) begin
          gpio_d[i] = sync_c[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_inc[i][CNT_WIDTH-1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter, level and edge-pulse registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BITS; i++) begin
        cnt_q[i] <= '0;
      end
      gpio_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      gpio_q <= gpio_d;
      rise_q <= ~gpio_q & gpio_d;
      fall_q <= gpio_q & ~gpio_d;
    end
  end

  assign gpio_o = gpio_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// -----------------------------------------------------------------------------
// tb_gpio_in_filter
// Self-checking bench for gpio_in_filter: directed scenarios plus a randomized
// run, all compared against a behavioural model of the pin conditioning rules.
// -----------------------------------------------------------------------------
module tb_gpio_in_filter;

  localparam int unsigned NB   = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned PW   = 16;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] pin_i;
  logic [NB-1:0] filt_en;
  logic [CW-1:0] filt_len;
  logic [PW-1:0] prescale_i;
  logic [NB-1:0] gpio_o;
  logic [NB-1:0] rise_o;
  logic [NB-1:0] fall_o;

  int n_checks;
  int n_fail;

  gpio_in_filter #(
    .NUM_BITS   (NB),
    .SYNC_STAGES(SYNC),
    .CNT_WIDTH  (CW),
    .PRE_WIDTH  (PW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pin_i     (pin_i),
    .filt_en   (filt_en),
    .filt_len  (filt_len),
    .prescale_i(prescale_i),
    .gpio_o    (gpio_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: pad history queue, elapsed-cycle prescaler, and per pin
  // a count of consecutive ticks the synchronised level has disagreed.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_gpio, m_rise, m_fall;
  int            m_run[NB];
  int            m_pc;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back('0);
    m_gpio = '0; m_rise = '0; m_fall = '0; m_pc = 0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] s;
    logic [NB-1:0] nv;
    bit            tick;
    int            need;
    s = hist[SYNC-1];
    hist.push_front(pin_i);
    void'(hist.pop_back());
    tick = (m_pc == int'(prescale_i));
    m_pc = (m_pc >= int'(prescale_i)) ? 0 : m_pc + 1;
    need = (filt_len == 0) ? 1 : int'(filt_len);
    nv = m_gpio;
    for (int i = 0; i < NB; i++) begin
      if (!filt_en[i]) begin
        nv[i] = s[i]; m_run[i] = 0;
      end else if (s[i] == m_gpio[i]) begin
        m_run[i] = 0;
      end else if (tick) begin
        if (m_run[i] + 1 >= need) begin nv[i] = s[i]; m_run[i] = 0; end
        else m_run[i] = m_run[i] + 1;
      end
    end
    m_rise = ~m_gpio & nv;
    m_fall = m_gpio & ~nv;
    m_gpio = nv;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0; pin_i = '0; filt_en = '0; filt_len = '0; prescale_i = '0;
    model_reset();
    #2;
    settle(3);
    n_checks++;
    if ({gpio_o, rise_o, fall_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got gpio=%h rise=%h fall=%h exp all 0", gpio_o, rise_o, fall_o);
    end
    reset_n = 1'b1;
    settle(4);
    n_checks++;
    if ({gpio_o, rise_o, fall_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_release_low: got gpio=%h rise=%h fall=%h exp all 0", gpio_o, rise_o, fall_o);
    end
  endtask

  task automatic test_bypass();
    pin_i[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (gpio_o[3] !== (k >= 3) || rise_o[3] !== (k == 3) || fall_o[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL bypass_edge%0d: got g=%b r=%b f=%b exp g=%b r=%b f=0", k, gpio_o[3], rise_o[3], fall_o[3], k >= 3, k == 3);
      end
      n_checks++;
      if ({gpio_o, rise_o, fall_o} !== {m_gpio, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL bypass_model: got %h/%h/%h exp %h/%h/%h", gpio_o, rise_o, fall_o, m_gpio, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_debounce();
    pin_i = '0; filt_en = '0; prescale_i = '0; filt_len = 8'd4;
    settle(4);
    filt_en[0] = 1'b1;
    step();
    pin_i[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (gpio_o[0] !== (k >= 6) || rise_o[0] !== (k == 6) || fall_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL debounce_edge%0d: got g=%b r=%b f=%b exp g=%b r=%b", k, gpio_o[0], rise_o[0], fall_o[0], k >= 6, k == 6);
      end
    end
    n_checks++;
    if ({gpio_o, rise_o, fall_o} !== {m_gpio, m_rise, m_fall}) begin
      n_fail++;
      $display("FAIL debounce_model: got %h/%h/%h exp %h/%h/%h", gpio_o, rise_o, fall_o, m_gpio, m_rise, m_fall);
    end
  endtask

  task automatic test_glitch();
    int events;
    pin_i[0] = 1'b0;
    settle(12);
    events = 0;
    // Three cycles high: one short of the four needed.
    pin_i[0] = 1'b0;
    @(negedge clk); pin_i[0] = 1'b1;
    step(); step(); step();
    pin_i[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (gpio_o[0] || rise_o[0] || fall_o[0]) events++;
    end
    n_checks++;
    if (events != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: got %0d cycles with activity exp 0", events);
    end
    // A following real change needs the full length again (count was cleared).
    pin_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (gpio_o[0] !== (k >= 6) || rise_o[0] !== (k == 6)) begin
        n_fail++;
        $display("FAIL glitch_recount%0d: got g=%b r=%b exp g=%b r=%b", k, gpio_o[0], rise_o[0], k >= 6, k == 6);
      end
    end
  endtask

  task automatic test_prescale();
    int rises, falls, rise_at;
    pin_i = '0; filt_en = '0;
    settle(4);
    filt_en[1] = 1'b1; filt_len = 8'd2; prescale_i = 16'd9;
    settle(7);
    rises = 0; falls = 0; rise_at = 0;
    pin_i[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (rise_o[1]) begin rises++; rise_at = k; end
      if (fall_o[1]) falls++;
      n_checks++;
      if ({gpio_o, rise_o, fall_o} !== {m_gpio, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL prescale_model%0d: got %h/%h/%h exp %h/%h/%h", k, gpio_o, rise_o, fall_o, m_gpio, m_rise, m_fall);
      end
    end
    n_checks++;
    if (rises != 1 || falls != 0 || rise_at < 13 || rise_at > 22 || gpio_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL prescale_rise: got rises=%0d falls=%0d at=%0d exp 1/0 at 13..22", rises, falls, rise_at);
    end
    rises = 0; falls = 0;
    pin_i[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (rise_o[1]) rises++;
      if (fall_o[1]) falls++;
    end
    n_checks++;
    if (rises != 0 || falls != 1 || gpio_o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL prescale_fall: got rises=%0d falls=%0d g=%b exp 0/1 g=0", rises, falls, gpio_o[1]);
    end
  endtask

  task automatic test_corners();
    pin_i = '0; filt_en = '0; prescale_i = '0; filt_len = '0;
    settle(4);
    // filt_len = 0 acts as 1: sync latency plus one tick.
    filt_en[2] = 1'b1;
    pin_i[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (gpio_o[2] !== (k == 3) || rise_o[2] !== (k == 3)) begin
        n_fail++;
        $display("FAIL len0_edge%0d: got g=%b r=%b exp %b", k, gpio_o[2], rise_o[2], k == 3);
      end
    end
    // Lowering filt_len below a running count accepts on the next tick.
    filt_len = 8'd200;
    filt_en[4] = 1'b1;
    pin_i[4] = 1'b1;
    settle(52);
    n_checks++;
    if (gpio_o[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL lower_len_hold: got g=%b exp 0", gpio_o[4]);
    end
    filt_len = 8'd5;
    step();
    n_checks++;
    if (gpio_o[4] !== 1'b1 || rise_o[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL lower_len_accept: got g=%b r=%b exp 1/1", gpio_o[4], rise_o[4]);
    end
    // Dropping filt_en mid-count follows the synchronised level next cycle.
    filt_len = 8'd200;
    filt_en[5] = 1'b1;
    pin_i[5] = 1'b1;
    settle(20);
    filt_en[5] = 1'b0;
    step();
    n_checks++;
    if (gpio_o[5] !== 1'b1 || rise_o[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_en_follow: got g=%b r=%b exp 1/1", gpio_o[5], rise_o[5]);
    end
    n_checks++;
    if ({gpio_o, rise_o, fall_o} !== {m_gpio, m_rise, m_fall}) begin
      n_fail++;
      $display("FAIL corners_model: got %h/%h/%h exp %h/%h/%h", gpio_o, rise_o, fall_o, m_gpio, m_rise, m_fall);
    end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] pat, acc, dup;
    pat = 32'hA5C3_0F91;
    filt_en = '1; filt_len = 8'd50; prescale_i = '0;
    pin_i = pat;
    settle(10);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({gpio_o, rise_o, fall_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got gpio=%h rise=%h fall=%h exp all 0", gpio_o, rise_o, fall_o);
    end
    settle(3);
    filt_en = '0;
    reset_n = 1'b1;
    acc = '0; dup = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      dup |= acc & rise_o;
      acc |= rise_o;
      n_checks++;
      if (fall_o !== '0 || (k == 3 && (gpio_o !== pat || rise_o !== pat))) begin
        n_fail++;
        $display("FAIL reset_release%0d: got g=%h r=%h f=%h exp g=r=%h at 3", k, gpio_o, rise_o, fall_o, pat);
      end
    end
    n_checks++;
    if (acc !== pat || dup !== '0) begin
      n_fail++;
      $display("FAIL reset_single_rise: got rises=%h dup=%h exp %h dup=0", acc, dup, pat);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      pin_i = pin_i ^ ($urandom() & $urandom() & $urandom());
      if (k % 200 == 0) filt_en = $urandom();
      if (k % 300 == 0) filt_len = CW'($urandom_range(0, 5));
      if (k % 250 == 0) prescale_i = PW'($urandom_range(0, 3));
      step();
      n_checks++;
      if ({gpio_o, rise_o, fall_o} !== {m_gpio, m_rise, m_fall} || (rise_o & fall_o) !== '0) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: got %h/%h/%h exp %h/%h/%h", k, gpio_o, rise_o, fall_o, m_gpio, m_rise, m_fall);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bypass();
    test_debounce();
    test_glitch();
    test_prescale();
    test_corners();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
